// File: rtl/jogador_automatico.sv
// Automatic player: latches four image indices and presses the matching buttons in order.
// Optional JOGADOR_ERRO_EN adds injetar_erro, which corrupts the position-3 press by +1.
module jogador_automatico #(
  parameter int T_PRESS = 4,
  parameter int T_GAP   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_auto,
  input  logic [7:0] indices,
  input  logic       indice_valido,
  input  logic       pronto,
`ifdef JOGADOR_ERRO_EN
  input  logic       injetar_erro,
`endif
  output logic [3:0] botoes,
  output logic       ativo,
  output logic       fim,
  output logic [3:0] n_jogadas,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    ESPERA_IDX = 4'd1,
    CARREGA    = 4'd2,
    PRESSIONA  = 4'd3,
    SOLTA      = 4'd4,
    PROXIMO    = 4'd5,
    FIM        = 4'd6
  } estado_t;

  localparam logic [15:0] TP_MAX = 16'(T_PRESS - 1);
  localparam logic [15:0] TG_MAX = 16'(T_GAP - 1);

  estado_t     estado_q, estado_d;
  logic [1:0]  pos_q, pos_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  njog_q, njog_d;
  logic [3:0]  botoes_q, botoes_d;
  logic        ativo_q, ativo_d;
  logic        fim_q, fim_d;
  logic [1:0]  sel;
`ifdef JOGADOR_ERRO_EN
  logic        erro_q, erro_d;
`endif

  always_comb begin
    estado_d = estado_q;
    pos_d    = pos_q;
    idx_d    = idx_q;
    njog_d   = njog_q;
`ifdef JOGADOR_ERRO_EN
    erro_d   = erro_q;
`endif
    // pronto aborts everything outside INICIAL, including a press in progress
    if (pronto && estado_q != INICIAL) begin
      estado_d = FIM;
    end else begin
      case (estado_q)
        INICIAL:    if (iniciar_auto) begin
                      estado_d = ESPERA_IDX;
                      njog_d   = 4'd0;
                    end
        ESPERA_IDX: if (indice_valido) begin
                      estado_d = CARREGA;
                      idx_d    = indices;
`ifdef JOGADOR_ERRO_EN
                      erro_d   = injetar_erro;
`endif
                    end
        CARREGA:    begin
                      pos_d    = 2'd0;
                      estado_d = PRESSIONA;
                    end
        PRESSIONA:  if (timer_q == TP_MAX) estado_d = SOLTA;
        SOLTA:      if (timer_q == TG_MAX) estado_d = PROXIMO;
        PROXIMO:    if (pos_q == 2'd3) estado_d = ESPERA_IDX;
                    else begin
                      pos_d    = pos_q + 2'd1;
                      estado_d = PRESSIONA;
                    end
        FIM:        if (!iniciar_auto && !pronto) estado_d = INICIAL;
        default:    estado_d = INICIAL;
      endcase
    end

    if (estado_d == PRESSIONA && estado_q != PRESSIONA && njog_q != 4'd15)
      njog_d = njog_q + 4'd1;

    // timer only runs while dwelling in a timed state
    if (estado_d == estado_q && (estado_q == PRESSIONA || estado_q == SOLTA))
      timer_d = timer_q + 16'd1;
    else
      timer_d = 16'd0;

    sel = idx_d[{pos_d, 1'b0} +: 2];
`ifdef JOGADOR_ERRO_EN
    if (erro_d && pos_d == 2'd3) sel = sel + 2'd1;
`endif
    botoes_d = (estado_d == PRESSIONA) ? (4'b0001 << sel) : 4'b0000;
    ativo_d  = (estado_d != INICIAL) && (estado_d != FIM);
    fim_d    = (estado_d == FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      pos_q    <= 2'd0;
      timer_q  <= 16'd0;
      idx_q    <= 8'd0;
      njog_q   <= 4'd0;
      botoes_q <= 4'd0;
      ativo_q  <= 1'b0;
      fim_q    <= 1'b0;
`ifdef JOGADOR_ERRO_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      pos_q    <= pos_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      njog_q   <= njog_d;
      botoes_q <= botoes_d;
      ativo_q  <= ativo_d;
      fim_q    <= fim_d;
`ifdef JOGADOR_ERRO_EN
      erro_q   <= erro_d;
`endif
    end
  end

  assign botoes    = botoes_q;
  assign ativo     = ativo_q;
  assign fim       = fim_q;
  assign n_jogadas = njog_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico with T_PRESS=3, T_GAP=2.
module tb_jogador_automatico;

  logic       clock = 1'b0;
  logic       reset, iniciar_auto, indice_valido, pronto;
  logic [7:0] indices;
`ifdef JOGADOR_ERRO_EN
  logic       injetar_erro;
`endif
  logic [3:0] botoes, n_jogadas, db_estado;
  logic       ativo, fim;

  int vectors = 0;
  int errs    = 0;

  jogador_automatico #(.T_PRESS(3), .T_GAP(2)) dut (
    .clock(clock), .reset(reset), .iniciar_auto(iniciar_auto),
    .indices(indices), .indice_valido(indice_valido), .pronto(pronto),
`ifdef JOGADOR_ERRO_EN
    .injetar_erro(injetar_erro),
`endif
    .botoes(botoes), .ativo(ativo), .fim(fim),
    .n_jogadas(n_jogadas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From ESPERA_IDX: pulse indice_valido, pass CARREGA, land on first PRESSIONA cycle
  task automatic start_txn(input logic [7:0] idx);
    indices = idx;
    indice_valido = 1'b1;
    tick();
    chk("carrega", 16'(db_estado), 16'd2);
    indice_valido = 1'b0;
    tick();
  endtask

  // exp_b holds the four expected one-hot presses, press 0 in the low nibble
  task automatic run_presses(input logic [15:0] exp_b, input int nbase, input int glitch_k);
    int ne;
    for (int k = 0; k < 4; k++) begin
      ne = nbase + k + 1;
      if (ne > 15) ne = 15;
      for (int c = 0; c < 3; c++) begin
        chk("press_botoes", 16'(botoes), 16'(exp_b[4*k +: 4]));
        chk("press_estado", 16'(db_estado), 16'd3);
        chk("press_njog", 16'(n_jogadas), 16'(ne));
        if (k == glitch_k && c == 0) begin
          indices = 8'hFF;
          indice_valido = 1'b1;
        end
        tick();
        indice_valido = 1'b0;
      end
      for (int g = 0; g < 3; g++) begin
        chk("gap_botoes", 16'(botoes), 16'd0);
        chk("gap_estado", 16'(db_estado), (g < 2) ? 16'd4 : 16'd5);
        tick();
      end
    end
    chk("back_espera", 16'(db_estado), 16'd1);
    chk("back_ativo", 16'(ativo), 16'd1);
  endtask

  initial begin
    reset = 1'b1; iniciar_auto = 1'b0; indice_valido = 1'b0; pronto = 1'b0;
    indices = 8'h00;
`ifdef JOGADOR_ERRO_EN
    injetar_erro = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("rst_estado", 16'(db_estado), 16'd0);
    chk("rst_botoes", 16'(botoes), 16'd0);
    chk("rst_njog", 16'(n_jogadas), 16'd0);
    chk("rst_ativo", 16'(ativo), 16'd0);
    chk("rst_fim", 16'(fim), 16'd0);

    // indice_valido in INICIAL is ignored
    indice_valido = 1'b1; indices = 8'hE4;
    tick();
    indice_valido = 1'b0;
    chk("idle_ignore", 16'(db_estado), 16'd0);

    iniciar_auto = 1'b1;
    tick();
    iniciar_auto = 1'b0;
    chk("start_estado", 16'(db_estado), 16'd1);
    chk("start_ativo", 16'(ativo), 16'd1);

    start_txn(8'b11100100);
    run_presses(16'b1000_0100_0010_0001, 0, -1);
    start_txn(8'b00000000);
    run_presses(16'b0001_0001_0001_0001, 4, -1);
    // indices=FF pulsed mid-press must not disturb the latched set
    start_txn(8'b11100100);
    run_presses(16'b1000_0100_0010_0001, 8, 1);
    // saturation of n_jogadas at 15
    start_txn(8'b00011011);
    run_presses(16'b0001_0010_0100_1000, 12, -1);
`ifdef JOGADOR_ERRO_EN
    injetar_erro = 1'b1;
    start_txn(8'b11100100);
    injetar_erro = 1'b0;
    run_presses(16'b0001_0100_0010_0001, 15, -1);
`endif

    // pronto during the 2nd cycle of a press
    start_txn(8'b11100100);
    tick();
    chk("abort_pre", 16'(botoes), 16'b0001);
    pronto = 1'b1;
    tick();
    chk("abort_botoes", 16'(botoes), 16'd0);
    chk("abort_fim", 16'(fim), 16'd1);
    chk("abort_estado", 16'(db_estado), 16'd6);
    chk("abort_ativo", 16'(ativo), 16'd0);
    pronto = 1'b0;
    tick();
    chk("fim_to_ini", 16'(db_estado), 16'd0);
    chk("fim_clear", 16'(fim), 16'd0);

    // restart clears the counter; then reset mid-SOLTA
    iniciar_auto = 1'b1;
    tick();
    iniciar_auto = 1'b0;
    chk("restart_njog", 16'(n_jogadas), 16'd0);
    start_txn(8'b00000000);
    tick(); tick(); tick();
    chk("solta_estado", 16'(db_estado), 16'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_estado", 16'(db_estado), 16'd0);
    chk("mrst_njog", 16'(n_jogadas), 16'd0);
    chk("mrst_botoes", 16'(botoes), 16'd0);
    indices = 8'hE4; indice_valido = 1'b1;
    tick();
    indice_valido = 1'b0;
    chk("mrst_ignore", 16'(db_estado), 16'd0);

    // pronto wins over indice_valido in ESPERA_IDX
    iniciar_auto = 1'b1;
    tick();
    iniciar_auto = 1'b0;
    indice_valido = 1'b1; pronto = 1'b1;
    tick();
    indice_valido = 1'b0; pronto = 1'b0;
    chk("prio_fim", 16'(db_estado), 16'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
